// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between N_REQ byte producers, timing each frame itself.
// Optional build macro UART_ARB_PRIO_EN: requester 0 wins whenever valid, leaving the RR pointer untouched.
//
// state  | meaning
// IDLE   | arbitrate pending valids, accept one byte
// STROBE | one-cycle enable pulse to uart_tx
// WAIT   | guard time for frame plus gap bits

module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int SYS_CLK_FRE = 50_000_000,
  parameter int BPS         = 9_600,
  parameter int GAP_BITS    = 1,
  localparam int ID_W       = $clog2(N_REQ)
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [N_REQ-1:0]     req_valid_i,
  input  logic [8*N_REQ-1:0]   req_data_i,
  output logic [N_REQ-1:0]     req_ready_o,
  output logic [7:0]           uart_tx_data_o,
  output logic                 uart_tx_en_o,
  output logic                 busy_o,
  output logic [ID_W-1:0]      grant_id_o
);

  localparam int BPS_CNT   = SYS_CLK_FRE / BPS;
  localparam int FRAME_CNT = BPS_CNT * (10 + GAP_BITS);
  localparam logic [23:0] FRAME_LAST = 24'(FRAME_CNT - 1);

  generate
    if (FRAME_CNT >= (1 << 24) || FRAME_CNT < 1) begin : g_frame_chk
      $error("uart_tx_arbiter: FRAME_CNT out of 24-bit counter range");
    end
    if (N_REQ < 2 || N_REQ > 8) begin : g_nreq_chk
      $error("uart_tx_arbiter: N_REQ must be 2..8");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STROBE = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [23:0]       r_wait_cnt;
  logic [ID_W-1:0]   r_ptr;
  logic [ID_W-1:0]   r_grant;
  logic [7:0]        r_tx_data;
  logic              w_any;
  logic              w_keep_ptr;
  logic [ID_W-1:0]   w_win;
  logic [7:0]        w_win_data;
  int                w_dist;
  int                w_best;

  // Winner is the valid requester at the smallest rotational distance past the pointer.
  always_comb begin
    w_any      = |req_valid_i;
    w_win      = '0;
    w_win_data = '0;
    w_keep_ptr = 1'b0;
    w_dist     = 0;
    w_best     = N_REQ;
    for (int j = 0; j < N_REQ; j++) begin
      w_dist = (j - int'(r_ptr) - 1 + 2 * N_REQ) % N_REQ;
      if (req_valid_i[j] && (w_dist < w_best)) begin
        w_best     = w_dist;
        w_win      = ID_W'(j);
        w_win_data = req_data_i[8*j +: 8];
      end
    end
`ifdef UART_ARB_PRIO_EN
    if (req_valid_i[0]) begin
      w_win      = '0;
      w_win_data = req_data_i[7:0];
      w_keep_ptr = 1'b1;
    end
`else
    w_keep_ptr = 1'b0;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= S_WAIT;
      r_wait_cnt <= '0;
      r_ptr      <= ID_W'(N_REQ - 1);
      r_grant    <= '0;
      r_tx_data  <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_tx_data <= w_win_data;
            r_grant   <= w_win;
            if (!w_keep_ptr) r_ptr <= w_win;
          end
        end
        S_STROBE: r_wait_cnt <= '0;
        S_WAIT:   r_wait_cnt <= r_wait_cnt + 24'd1;
        default:  r_wait_cnt <= r_wait_cnt;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_any) w_next = S_STROBE;
      S_STROBE: w_next = S_WAIT;
      S_WAIT:   if (r_wait_cnt == FRAME_LAST) w_next = S_IDLE;
      default:  w_next = S_WAIT;
    endcase
  end

  always_comb begin
    req_ready_o = '0;
    if (r_state == S_IDLE && w_any) req_ready_o[w_win] = 1'b1;
    uart_tx_en_o = (r_state == S_STROBE);
    busy_o       = (r_state != S_IDLE);
  end

  assign uart_tx_data_o = r_tx_data;
  assign grant_id_o     = r_grant;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: stimulus pushes expected grants, a monitor pops and checks them.
module tb_uart_tx_arbiter;
  localparam int N     = 4;
  localparam int FRAME = 110;
  localparam int SLOT  = FRAME + 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [N-1:0]     valid = '0;
  logic [8*N-1:0]   data = '0;
  logic [N-1:0]     ready;
  logic [7:0]       txd;
  logic             txen;
  logic             busy;
  logic [1:0]       gid;

  uart_tx_arbiter #(
    .N_REQ(N), .SYS_CLK_FRE(100), .BPS(10), .GAP_BITS(1)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(valid), .req_data_i(data),
    .req_ready_o(ready), .uart_tx_data_o(txd), .uart_tx_en_o(txen),
    .busy_o(busy), .grant_id_o(gid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [7:0] d;
    int         gap;
  } exp_t;

  exp_t       exp_q[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         last_ref = 0;
  int         m_ptr = N - 1;
  logic [7:0] src [N][3];
  int         cnt [N];
  int         head [N];

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge rst_n) last_ref = cyc;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: expected grant order from round-robin rules over the pending byte counts.
  task automatic prep(input int first_gap);
    int   rem [N];
    int   pos [N];
    int   w, j, left;
    bit   first;
    exp_t e;
    first = 1'b1;
    left  = 0;
    for (int i = 0; i < N; i++) begin
      rem[i] = cnt[i]; pos[i] = 0; head[i] = 0; left += cnt[i];
    end
    while (left > 0) begin
      w = -1;
`ifdef UART_ARB_PRIO_EN
      if (rem[0] > 0) w = 0;
`endif
      if (w < 0) begin
        for (int k = 1; k <= N; k++) begin
          j = (m_ptr + k) % N;
          if (w < 0 && rem[j] > 0) w = j;
        end
        m_ptr = w;
      end
      e.id  = w;
      e.d   = src[w][pos[w]];
      e.gap = first ? first_gap : SLOT;
      exp_q.push_back(e);
      pos[w]++; rem[w]--; left--;
      first = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (cnt[i] > 0) begin
        valid[i] = 1'b1;
        data[8*i +: 8] = src[i][0];
      end
    end
  endtask

  task automatic drain();
    int left, budget;
    logic [N-1:0] rdy;
    left = 0;
    for (int i = 0; i < N; i++) left += cnt[i];
    budget = left * SLOT + 300;
    while (left > 0 && budget > 0) begin
      @(negedge clk);
      rdy = ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (rdy[i] && valid[i]) begin
          head[i]++; left--;
          if (head[i] < cnt[i]) data[8*i +: 8] = src[i][head[i]];
          else valid[i] = 1'b0;
        end
      end
      budget--;
    end
    chk("drain_all_accepted", left, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    valid = '0;
    exp_q.delete();
    m_ptr = N - 1;
    #1;
    chk("rst_ready", ready, 0);
    chk("rst_data", txd, 0);
    chk("rst_en", txen, 0);
    chk("rst_grant", gid, 0);
    chk("rst_busy", busy, 1);
    repeat (2) @(posedge clk);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic set_counts(input int c0, input int c1, input int c2, input int c3);
    cnt[0] = c0; cnt[1] = c1; cnt[2] = c2; cnt[3] = c3;
  endtask

  // Monitor: en, data and grant are checked every cycle; each ready pulse pops one expectation.
  logic [7:0] mon_d = '0;
  int         mon_g = 0;
  bit         mon_en = 1'b0;
  exp_t       mon_e;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_en = 1'b0; mon_d = '0; mon_g = 0;
      end else begin
        chk("en_pulse", txen, mon_en);
        chk("data_hold", txd, mon_d);
        chk("grant_id", gid, mon_g);
        if (txen) chk("busy_strobe", busy, 1);
        mon_en = 1'b0;
        if (ready != '0) begin
          chk("busy_idle", busy, 0);
          if (exp_q.size() == 0) begin
            chk("unexpected_ready", ready, 0);
          end else begin
            mon_e = exp_q.pop_front();
            chk("ready_onehot", ready, 1 << mon_e.id);
            if (mon_e.gap >= 0) chk("grant_gap", cyc - last_ref, mon_e.gap);
            mon_d  = mon_e.d;
            mon_g  = mon_e.id;
            mon_en = 1'b1;
          end
          last_ref = cyc;
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    #1;
    // guard frame after reset, then requester 0
    do_reset();
    set_counts(1, 0, 0, 0);
    src[0][0] = 8'h11;
    prep(FRAME);
    release_reset();
    drain();

    // all four held: order 0,1,2,3,0
    do_reset();
    set_counts(2, 1, 1, 1);
    for (int i = 0; i < N; i++) src[i][0] = 8'hA0 + 8'(i);
    src[0][1] = 8'hA0;
    prep(FRAME);
    release_reset();
    drain();

    // req 2 then req 1 arriving mid-WAIT
    set_counts(0, 0, 1, 0);
    src[2][0] = 8'h55;
    prep(SLOT);
    drain();
    repeat (50) @(posedge clk);
    #1;
    set_counts(0, 1, 0, 0);
    src[1][0] = 8'h9E;
    prep(SLOT);
    drain();

    // reset 30 cycles into WAIT
    repeat (30) @(posedge clk);
    #2;
    do_reset();
    set_counts(0, 0, 0, 1);
    src[3][0] = 8'hC3;
    prep(FRAME);
    release_reset();
    drain();

    // one-cycle valid during WAIT must be ignored
    repeat (20) @(posedge clk);
    #1;
    valid[3] = 1'b1;
    data[31:24] = 8'h3C;
    @(posedge clk);
    #1 valid[3] = 1'b0;
    repeat (120) @(posedge clk);
    @(negedge clk);
    chk("idle_after_drop", busy, 0);
    chk("no_pending", exp_q.size(), 0);

    // valid 0111 stimulus: plain RR gives 0,1,2,0
    do_reset();
    set_counts(2, 1, 1, 0);
    for (int i = 0; i < N; i++) begin
      src[i][0] = 8'($urandom);
      src[i][1] = 8'($urandom);
    end
    prep(FRAME);
    release_reset();
    drain();

    // randomized batches
    for (int b = 0; b < 6; b++) begin
      w = $urandom_range(0, 250);
      repeat (w) @(posedge clk);
      #1;
      set_counts($urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3));
      if (cnt[0] + cnt[1] + cnt[2] + cnt[3] == 0) cnt[b % N] = 1;
      for (int i = 0; i < N; i++)
        for (int k = 0; k < 3; k++) src[i][k] = 8'($urandom);
      prep((w <= FRAME) ? SLOT : w + 1);
      drain();
    end

    repeat (5) @(posedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
